alu_divider: RTL and testbench
==============================

# alu_divider

Iterative restoring divider that performs the inverse of the ALU's Karatsuba multiplier path: it takes a `DOUT_W`-bit dividend (product-width) and a `DIN_W`-bit divisor and returns a `DIN_W`-bit quotient and remainder. It sits beside the multiplier under the ALU, uses the same clock, reset and operand widths, and uses a valid/ready handshake because it takes multiple cycles per operation.

## Interface
- `DIN_W`, default 8: divisor, quotient and remainder width.
- `DOUT_W`, default `2*DIN_W`: dividend width. Must equal `2*DIN_W`.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `dividend_i`  in  `DOUT_W`  dividend.
- `divisor_i`  in  `DIN_W`  divisor.
- `op_valid_i`  in  1  request valid.
- `ready_o`  out  1  divider idle; a request is accepted this cycle if `op_valid_i` is also high.
- `quotient_o`  out  `DIN_W`  quotient.
- `remainder_o`  out  `DIN_W`  remainder.
- `div_by_zero_o`  out  1  error flag: the divisor was 0.
- `overflow_o`  out  1  error flag: the quotient does not fit in `DIN_W` bits.
- `data_valid`  out  1  one-cycle result strobe.

## Operation
- States (`div_state_t`): IDLE, BUSY, DONE.
- IDLE:
  - `ready_o`=1.
  - On accept (`op_valid_i && ready_o`), register `dividend_i` and `divisor_i`.
- Classification at accept:
  - If `divisor_i`==0, the next state is DONE with `div_by_zero_o`=1 and `overflow_o`=0.
  - Else if `dividend_i[DOUT_W-1:DIN_W] >= divisor_i`, the next state is DONE with `overflow_o`=1.
  - Otherwise the next state is BUSY.
- BUSY initialisation:
  - Partial remainder R (`DIN_W+1` bits) = dividend high half.
  - Low-half shift register = dividend low half.
  - Iteration counter = 0.
- BUSY, each cycle:
  - R' = {R[DIN_W-1:0], next low-half bit, MSB first}.
  - If R' >= divisor: R = R' − divisor and the quotient bit is 1. Otherwise R = R' and the quotient bit is 0.
  - Shift the quotient bit into the quotient register from the LSB.
  - After `DIN_W` iterations, go to DONE.
- DONE:
  - `data_valid`=1 for exactly one cycle; `ready_o`=0.
  - Next state is IDLE.
- Result values:
  - Normal: `quotient_o` = floor(dividend/divisor); `remainder_o` = dividend mod divisor.
  - Divide by zero: `quotient_o` = all ones; `remainder_o` = `dividend[DIN_W-1:0]`.
  - Overflow: `quotient_o` = all ones; `remainder_o` = 0.
- Result hold:
  - `quotient_o`, `remainder_o`, `div_by_zero_o` and `overflow_o` hold their values until the next DONE.
  - They are not cleared on return to IDLE.
- `op_valid_i` while BUSY or DONE is ignored. Requests are not queued, and operand changes after accept have no effect.

## Timing
- Reset: state=IDLE. `ready_o`=1 from the first cycle after reset. `data_valid`=0, `quotient_o`=0, `remainder_o`=0, `div_by_zero_o`=0, `overflow_o`=0.
- Accept in cycle 0 (a normal request):
  - BUSY in cycles 1..`DIN_W`.
  - DONE and `data_valid` in cycle `DIN_W+1`.
  - `ready_o` high again in cycle `DIN_W+2`.
  - For `DIN_W`=8: `data_valid` in cycle 9, next accept possible in cycle 10.
- Error requests: DONE in cycle 1, `ready_o` again in cycle 2.
- `ready_o` is a registered state decode; it does not depend combinationally on `op_valid_i`.
- `rst` asserted in any state returns the block to the reset values on the next edge. An in-flight operation is discarded with no `data_valid`.
- Back-to-back throughput: one result per `DIN_W+2` cycles.

## Structure
- `alu_pkg` gains:
  - `div_state_t` (2-bit enum: IDLE, BUSY, DONE).
  - `DIV` added to `opcode_t` for later ALU integration.
- Iteration counter width: `$clog2(DIN_W+1)`.
- Sub-module `alu_div_step`:
  - Combinational, one restoring step.
  - Inputs: R, incoming bit, divisor.
  - Outputs: next R, quotient bit.
- The top holds the FSM, operand and quotient registers, and error classification.

## Test plan
- `DIN_W`=8; `dividend_i`=16'd100, `divisor_i`=8'd7, accept in cycle 0 → `data_valid` only in cycle 9, `quotient_o`=14, `remainder_o`=2, both flags 0.
- 16'hFE01 / 8'hFF → `quotient_o`=8'hFF, `remainder_o`=0. Also 16'h00FF / 8'h01 → `quotient_o`=8'hFF, `remainder_o`=0.
- 16'h1234 / 8'h00 → `data_valid` in cycle 1, `div_by_zero_o`=1, `overflow_o`=0, `quotient_o`=8'hFF, `remainder_o`=8'h34; `ready_o`=1 in cycle 2.
- 16'h0100 / 8'h01 → `overflow_o`=1 in cycle 1, `quotient_o`=8'hFF, `remainder_o`=0. Also 16'h0500 / 8'h06 → normal path, `quotient_o`=213, `remainder_o`=2.
- Hold `op_valid_i`=1 with changing operands throughout BUSY → only the first request is processed, `data_valid` pulses once. The second accept occurs in cycle 10 and produces the correct result in cycle 19.
- Assert `rst` in cycle 4 of a BUSY operation → no `data_valid`, all outputs 0, `ready_o`=1 the cycle after reset deasserts. A fresh 100/7 then completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes for the datapath and the divider FSM state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_div_step.sv
// One combinational restoring-division step: shift in one dividend bit, then
// subtract the divisor when it fits.
module alu_div_step #(
  parameter int DIN_W = 8
) (
  input  logic [DIN_W-1:0] r_i,
  input  logic             bit_i,
  input  logic [DIN_W-1:0] divisor_i,
  output logic [DIN_W-1:0] r_o,
  output logic             q_o
);

  logic [DIN_W:0] r_sh;
  logic [DIN_W:0] r_sub;

  // The incoming R is always below the divisor, so the shifted value fits
  // DIN_W+1 bits and the restored result fits back into DIN_W bits.
  assign r_sh  = {r_i, bit_i};
  assign r_sub = r_sh - {1'b0, divisor_i};
  assign q_o   = (r_sh >= {1'b0, divisor_i});
  assign r_o   = q_o ? r_sub[DIN_W-1:0] : r_sh[DIN_W-1:0];

endmodule

// File: rtl/alu_divider.sv
// Iterative restoring divider: DOUT_W-bit dividend / DIN_W-bit divisor, one
// quotient bit per cycle, valid/ready handshake, errors resolved at accept.
module alu_divider
  import alu_pkg::*;
#(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 2*DIN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DOUT_W-1:0] dividend_i,
  input  logic [DIN_W-1:0]  divisor_i,
  input  logic              op_valid_i,
  output logic              ready_o,
  output logic [DIN_W-1:0]  quotient_o,
  output logic [DIN_W-1:0]  remainder_o,
  output logic              div_by_zero_o,
  output logic              overflow_o,
  output logic              data_valid
);

  localparam int CW = $clog2(DIN_W+1);
  localparam logic [CW-1:0] LAST = CW'(DIN_W-1);

  div_state_t       state_q;
  logic [DIN_W-1:0] r_q, lo_q, div_q, quo_sh_q;
  logic [CW-1:0]    cnt_q;
  logic [DIN_W-1:0] quo_q, rem_q;
  logic             dbz_q, ovf_q, dv_q;

  logic [DIN_W-1:0] r_d;
  logic             qbit_d;
  logic [DIN_W-1:0] hi_w;

  assign hi_w = dividend_i[DOUT_W-1:DIN_W];

  alu_div_step #(.DIN_W(DIN_W)) u_step (
    .r_i       (r_q),
    .bit_i     (lo_q[DIN_W-1]),
    .divisor_i (div_q),
    .r_o       (r_d),
    .q_o       (qbit_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      lo_q     <= '0;
      div_q    <= '0;
      quo_sh_q <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: if (op_valid_i) begin
          div_q    <= divisor_i;
          r_q      <= hi_w;
          lo_q     <= dividend_i[DIN_W-1:0];
          quo_sh_q <= '0;
          cnt_q    <= '0;
          if (divisor_i == '0) begin
            state_q <= DONE;
            dv_q    <= 1'b1;
            quo_q   <= '1;
            rem_q   <= dividend_i[DIN_W-1:0];
            dbz_q   <= 1'b1;
            ovf_q   <= 1'b0;
          end else if (hi_w >= divisor_i) begin
            // Quotient would need more than DIN_W bits.
            state_q <= DONE;
            dv_q    <= 1'b1;
            quo_q   <= '1;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b1;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          r_q      <= r_d;
          lo_q     <= {lo_q[DIN_W-2:0], 1'b0};
          quo_sh_q <= {quo_sh_q[DIN_W-2:0], qbit_d};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            dv_q    <= 1'b1;
            quo_q   <= {quo_sh_q[DIN_W-2:0], qbit_d};
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o       = (state_q == IDLE);
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;
  assign overflow_o    = ovf_q;
  assign data_valid    = dv_q;

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: vector table plus handshake and reset sequences.
module tb_alu_divider;

  localparam int DIN_W  = 8;
  localparam int DOUT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DOUT_W-1:0] dividend_i;
  logic [DIN_W-1:0]  divisor_i;
  logic              op_valid_i;
  logic              ready_o;
  logic [DIN_W-1:0]  quotient_o;
  logic [DIN_W-1:0]  remainder_o;
  logic              div_by_zero_o;
  logic              overflow_o;
  logic              data_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_divider #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .op_valid_i    (op_valid_i),
    .ready_o       (ready_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o),
    .overflow_o    (overflow_o),
    .data_valid    (data_valid)
  );

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [7:0] q, input logic [7:0] r,
                          input logic dbz, input logic ovf);
    chk({name, " quotient"}, 32'(quotient_o), 32'(q));
    chk({name, " remainder"}, 32'(remainder_o), 32'(r));
    chk({name, " div_by_zero"}, 32'(div_by_zero_o), 32'(dbz));
    chk({name, " overflow"}, 32'(overflow_o), 32'(ovf));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk({name, " ready timeout"}, 32'(ready_o), 32'd1);
  endtask

  // Accept at the next edge, then count cycles until the result strobe.
  task automatic run_vec(input string name, input vec_t v);
    int lat = 0;
    wait_ready(name);
    dividend_i = v.dvd;
    divisor_i  = v.dvs;
    op_valid_i = 1'b1;
    @(posedge clk);
    #1;
    op_valid_i = 1'b0;
    dividend_i = ~v.dvd;
    divisor_i  = v.dvs ^ 8'h5A;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (data_valid) lat = k;
    end
    chk({name, " latency"}, 32'(lat), 32'(v.lat));
    chk_outs(name, v.q, v.r, v.dbz, v.ovf);
    @(negedge clk);
    chk({name, " strobe single"}, 32'(data_valid), 32'd0);
    chk({name, " ready after"}, 32'(ready_o), 32'd1);
    chk({name, " quotient held"}, 32'(quotient_o), 32'(v.q));
  endtask

  vec_t vecs[10];

  initial begin
    int pulses;
    int first_dv, second_dv;
    logic ready10;

    vecs[0] = '{16'd100,   8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 9};
    vecs[1] = '{16'hFE01,  8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0, 9};
    vecs[2] = '{16'h00FF,  8'h01,  8'hFF,  8'h00,  1'b0, 1'b0, 9};
    vecs[3] = '{16'h1234,  8'h00,  8'hFF,  8'h34,  1'b1, 1'b0, 1};
    vecs[4] = '{16'h0100,  8'h01,  8'hFF,  8'h00,  1'b0, 1'b1, 1};
    vecs[5] = '{16'h0500,  8'h06,  8'd213, 8'd2,   1'b0, 1'b0, 9};
    vecs[6] = '{16'hFFFF,  8'hFF,  8'hFF,  8'h00,  1'b0, 1'b1, 1};
    vecs[7] = '{16'h00FF,  8'hFF,  8'h01,  8'h00,  1'b0, 1'b0, 9};
    vecs[8] = '{16'd1000,  8'd33,  8'd30,  8'd10,  1'b0, 1'b0, 9};
    vecs[9] = '{16'd0,     8'd5,   8'd0,   8'd0,   1'b0, 1'b0, 9};

    rst = 1'b1;
    op_valid_i = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'(ready_o), 32'd1);
    chk("reset data_valid", 32'(data_valid), 32'd0);
    chk_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Valid held high with changing operands: only accepts in idle cycles count.
    wait_ready("hold");
    dividend_i = 16'd100;
    divisor_i  = 8'd7;
    op_valid_i = 1'b1;
    @(posedge clk);
    pulses = 0; first_dv = 0; second_dv = 0; ready10 = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      #1;
      if (k < 10) begin
        dividend_i = 16'(k * 1234);
        divisor_i  = 8'(k);
      end else begin
        dividend_i = 16'h0500;
        divisor_i  = 8'h06;
      end
      op_valid_i = (k <= 10);
      @(negedge clk);
      if (k == 10) ready10 = ready_o;
      if (data_valid) begin
        pulses++;
        if (pulses == 1) begin
          first_dv = k;
          chk_outs("hold first", 8'd14, 8'd2, 1'b0, 1'b0);
        end else if (pulses == 2) begin
          second_dv = k;
          chk_outs("hold second", 8'd213, 8'd2, 1'b0, 1'b0);
        end
      end
      @(posedge clk);
    end
    op_valid_i = 1'b0;
    chk("hold pulses", 32'(pulses), 32'd2);
    chk("hold first cycle", 32'(first_dv), 32'd9);
    chk("hold ready cycle10", 32'(ready10), 32'd1);
    chk("hold second cycle", 32'(second_dv), 32'd19);

    // Reset in cycle 4 of a busy operation discards it.
    wait_ready("rst");
    dividend_i = 16'd100;
    divisor_i  = 8'd7;
    op_valid_i = 1'b1;
    @(posedge clk);
    #1 op_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst ready", 32'(ready_o), 32'd1);
    chk("midrst data_valid", 32'(data_valid), 32'd0);
    chk_outs("midrst", 8'h00, 8'h00, 1'b0, 1'b0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (data_valid) pulses++;
    end
    chk("midrst no strobe", 32'(pulses), 32'd0);
    run_vec("after rst", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
